// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its command sequencer: opcode encoding,
// sequencer states and the default datapath width.
package alu_pkg;

  localparam int DEF_WIDTH = 32;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_PASS_A = 3'b000;
  localparam opcode_t OP_ADD    = 3'b001;
  localparam opcode_t OP_SUB    = 3'b010;
  localparam opcode_t OP_AND    = 3'b011;
  localparam opcode_t OP_OR     = 3'b100;
  localparam opcode_t OP_INC    = 3'b101;
  localparam opcode_t OP_DEC    = 3'b110;
  localparam opcode_t OP_PASS_B = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

endpackage

// File: rtl/alu_rep_counter.sv
// Repeat counter for the sequencer: loads max(count,1), decrements once per
// iteration and flags the final iteration.
module alu_rep_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [CNT_W-1:0] remaining_q, remaining_d;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    remaining_d = remaining_q;
    if (load_i) begin
      remaining_d = (load_val_i == '0) ? CNT_W'(1) : load_val_i;
    end else if (dec_i && (remaining_q != '0)) begin
      remaining_d = remaining_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_q <= '0;
    end else begin
      remaining_q <= remaining_d;
    end
  end

  assign last_o = (remaining_q == CNT_W'(1));

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues commands to an external combinational ALU, chains the result through
// the accumulator for the requested repeat count and returns it on a response channel.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  opcode_t          cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  output opcode_t          alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  opcode_t          op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             cnt_load, cnt_dec, cnt_last;

  alu_rep_counter #(.CNT_W(CNT_W)) u_rep_counter (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cnt_load),
    .load_val_i(cmd_count),
    .dec_i     (cnt_dec),
    .last_o    (cnt_last)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_data_d = rsp_data_q;
    rsp_zero_d = rsp_zero_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d     = cmd_op;
          a_d      = acc_q;
          b_d      = cmd_data;
          cnt_load = 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        // alu_y has settled for a full cycle from the operands registered last edge.
        acc_d   = alu_y;
        cnt_dec = 1'b1;
        if (cnt_last) begin
          rsp_data_d = alu_y;
          rsp_zero_d = (alu_y == '0);
          state_d    = RESP;
        end else begin
          a_d = alu_y;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      op_q       <= OP_PASS_A;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_data_q <= rsp_data_d;
      rsp_zero_q <= rsp_zero_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign alu_op    = op_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench: behavioural ALU alongside the sequencer, plus a reference
// model that iterates the opcode semantics on a model accumulator.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk, rst;
  logic             cmd_valid, cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_y;
  logic             rsp_valid, rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;

  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] model_acc;

  alu_cmd_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .cmd_count(cmd_count),
    .alu_op   (alu_op),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_y    (alu_y),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_zero (rsp_zero)
  );

  function automatic logic [WIDTH-1:0] alu_f(input logic [2:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    return a;
      3'd1:    return a + b;
      3'd2:    return a - b;
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return a + 1;
      3'd6:    return a - 1;
      default: return b;
    endcase
  endfunction

  assign alu_y = alu_f(alu_op, alu_a, alu_b);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Issue one command at a negedge, follow it through EXEC and RESP, and retire it.
  task automatic do_cmd(input logic [2:0] op, input logic [WIDTH-1:0] data,
                        input logic [CNT_W-1:0] count, input int hold, input bit poke);
    int               n;
    int               idx;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] exp_a[$];
    n = (count == 0) ? 1 : int'(count);
    a = model_acc;
    for (int i = 0; i < n; i++) begin
      exp_a.push_back(a);
      a = alu_f(op, a, data);
    end

    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_idle: got %b expected 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_count = count;
    @(negedge clk);
    cmd_valid = 1'b0;

    idx = 0;
    while (rsp_valid !== 1'b1 && idx <= n) begin
      if (idx < n) begin
        checks++;
        if (alu_a !== exp_a[idx] || alu_op !== op || alu_b !== data || cmd_ready !== 1'b0) begin
          errors++;
          $display("FAIL exec_step%0d: alu_a=%h op=%0d b=%h rdy=%b expected alu_a=%h op=%0d b=%h rdy=0",
                   idx, alu_a, alu_op, alu_b, cmd_ready, exp_a[idx], op, data);
        end
      end
      idx++;
      @(negedge clk);
    end
    checks++;
    if (idx !== n) begin
      errors++;
      $display("FAIL latency: rsp_valid after %0d edges, expected %0d", idx, n);
    end
    checks++;
    if (rsp_data !== a || rsp_zero !== (a == '0)) begin
      errors++;
      $display("FAIL rsp_data: got %h zero=%b expected %h zero=%b", rsp_data, rsp_zero, a, (a == '0));
    end

    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      if (poke && h == 1) begin
        cmd_valid = 1'b1;
        cmd_op    = OP_PASS_B;
        cmd_data  = 32'hDEAD_BEEF;
        cmd_count = 4'd1;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== a || rsp_zero !== (a == '0) || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL rsp_hold%0d: valid=%b data=%h zero=%b rdy=%b expected 1 %h %b 0",
                 h, rsp_valid, rsp_data, rsp_zero, cmd_ready, a, (a == '0));
      end
    end

    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rsp_retire: valid=%b rdy=%b expected 0 1", rsp_valid, cmd_ready);
    end
    model_acc = a;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model_acc = '0;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_zero !== 1'b1 ||
        alu_op !== 3'b000 || alu_a !== '0 || alu_b !== '0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b valid=%b data=%h zero=%b op=%0d a=%h b=%h expected 1 0 0 1 0 0 0",
               cmd_ready, rsp_valid, rsp_data, rsp_zero, alu_op, alu_a, alu_b);
    end
  endtask

  task automatic test_load_add_sub();
    do_cmd(OP_PASS_B, 32'h0000_0005, 4'd1, 0, 1'b0);
    do_cmd(OP_ADD,    32'h0000_0003, 4'd1, 0, 1'b0);
    do_cmd(OP_SUB,    32'h0000_0008, 4'd1, 0, 1'b0);
  endtask

  task automatic test_wrap_chain();
    do_cmd(OP_PASS_B, 32'hFFFF_FFFE, 4'd1, 0, 1'b0);
    do_cmd(OP_INC,    32'h1234_5678, 4'd3, 0, 1'b0);
    checks++;
    if (model_acc !== 32'h0000_0001) begin
      errors++;
      $display("FAIL wrap_model: got %h expected 00000001", model_acc);
    end
  endtask

  task automatic test_count_zero();
    do_cmd(OP_PASS_B, 32'h0000_0000, 4'd1, 0, 1'b0);
    do_cmd(OP_DEC,    32'h0000_0000, 4'd0, 0, 1'b0);
    do_cmd(OP_PASS_A, 32'hA5A5_A5A5, 4'd15, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_cmd(OP_PASS_B, 32'h0000_0042, 4'd1, 5, 1'b1);
    do_cmd(OP_PASS_A, 32'h0000_0000, 4'd2, 0, 1'b0);
  endtask

  task automatic test_reset_mid_exec();
    int rises;
    cmd_valid = 1'b1;
    cmd_op    = OP_INC;
    cmd_data  = 32'h0;
    cmd_count = 4'd10;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_zero !== 1'b1 || alu_a !== '0) begin
      errors++;
      $display("FAIL reset_mid_exec: valid=%b rdy=%b zero=%b a=%h expected 0 1 1 0",
               rsp_valid, cmd_ready, rsp_zero, alu_a);
    end
    rst = 1'b0;
    model_acc = '0;
    rises = 0;
    repeat (15) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) rises++;
    end
    checks++;
    if (rises != 0) begin
      errors++;
      $display("FAIL dropped_cmd: rsp_valid high %0d cycles expected 0", rises);
    end
    do_cmd(OP_PASS_A, 32'h7777_7777, 4'd3, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      do_cmd(3'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)),
             int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_data  = '0;
    cmd_count = '0;
    rsp_ready = 1'b0;
    model_acc = '0;
    @(negedge clk);
    test_reset();
    test_load_add_sub();
    test_wrap_chain();
    test_count_zero();
    test_backpressure();
    test_reset_mid_exec();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Drives the shared 3-bit-opcode, 32-bit ALU from the issuing side.
- Accepts operation commands over a valid/ready handshake and presents opcode and operands to an external combinational ALU.
- Captures the ALU result into an internal accumulator, optionally repeats the operation N times, and returns the accumulator over a valid/ready response channel.
- Sits between the control/test-stimulus logic and the ALU datapath.

Parameters:
- WIDTH, 32, data/accumulator width; must equal the ALU operand width.
- CNT_W, 4, width of the repeat-count field.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  3  ALU opcode.
- cmd_data  input  WIDTH  B operand.
- cmd_count  input  CNT_W  repeat count; 0 is treated as 1.
- alu_op  output  3  opcode to the ALU.
- alu_a  output  WIDTH  A operand to the ALU (accumulator path).
- alu_b  output  WIDTH  B operand to the ALU.
- alu_y  input  WIDTH  ALU result, combinational from alu_op/alu_a/alu_b.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_data  output  WIDTH  accumulator value.
- rsp_zero  output  1  rsp_data == 0.

Behaviour:
- Opcode encoding is shared with the ALU: 000 A, 001 A+B, 010 A-B, 011 A&B, 100 A|B, 101 A+1, 110 A-1, 111 B.
- All ALU arithmetic is modulo 2^WIDTH. The sequencer adds no carry or overflow.
- Reset (synchronous, active-high) sets:
  - state IDLE, acc 0, remaining 0
  - alu_op 000, alu_a 0, alu_b 0
  - rsp_valid 0, rsp_data 0, rsp_zero 1
  - cmd_ready 1 in the first cycle after reset.
- States: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: alu_op<=cmd_op, alu_a<=acc, alu_b<=cmd_data, remaining<=max(cmd_count,1); go to EXEC.
- EXEC:
  - cmd_ready=0. The ALU has one full cycle to settle.
  - Each edge: acc<=alu_y and remaining<=remaining-1.
  - If remaining>1: alu_a<=alu_y (chain), stay in EXEC.
  - If remaining==1: rsp_data<=alu_y, rsp_zero<=(alu_y==0), rsp_valid<=1, go to RESP.
- RESP:
  - rsp_valid held high; rsp_data and rsp_zero stable until accepted.
  - On rsp_ready: rsp_valid<=0, go to IDLE.
  - No same-cycle command bypass: cmd_ready rises the cycle after acceptance.
- Latency: the accept edge is cycle 0. rsp_valid rises after edge N, where N = effective count. Maximum N is 2^CNT_W-1.
- alu_op and alu_b stay constant for the whole command. Only alu_a changes, once per iteration.
- Accumulator persists across commands. Op 111 loads it; op 000 with any count returns it unchanged.
- The command channel ignores cmd_valid outside IDLE; no buffering. Commands are not lost because cmd_ready=0 outside IDLE.
- rsp_ready is ignored when rsp_valid=0.
- Reset mid-EXEC or mid-RESP:
  - The in-flight command is dropped; no response is produced.
  - acc returns to 0 and rsp_valid drops on that edge.
- The sequencer never drives an opcode outside 000-111, so the ALU's default (high-Z) branch is never exercised.

Decomposition:
- Shared package alu_pkg holds:
  - the opcode constants (OP_PASS_A, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_INC, OP_DEC, OP_PASS_B)
  - the 3-bit opcode typedef
  - the state enum (IDLE, EXEC, RESP)
  - the WIDTH default.
- No sub-module is required. The ALU stays external and is instantiated alongside in the bench/top.
- Optionally factor the repeat counter as alu_rep_counter (load, decrement, last flag).

Test Plan:
- Reset, then cmd 111 data 0x0000_0005 count 1 -> rsp_valid one cycle after accept, rsp_data 0x5, rsp_zero 0.
- After load 0x5: cmd 001 data 0x3 count 1 -> 0x8; then cmd 010 data 0x8 count 1 -> 0x0 with rsp_zero 1.
- Load 0xFFFF_FFFE, cmd 101 count 3 -> rsp_valid exactly 3 cycles after accept, rsp_data 0x1 (wrap), alu_a steps FFFFFFFE, FFFFFFFF, 0.
- cmd_count 0 with op 110 on acc 0 -> treated as 1, rsp_data 0xFFFF_FFFF.
- Hold rsp_ready low 5 cycles -> rsp_valid and rsp_data stable, cmd_ready 0, and a cmd_valid pulse is not accepted. Raise rsp_ready -> cmd_ready high the next cycle.
- Assert rst during EXEC of a count-10 command -> rsp_valid never rises, acc 0, cmd_ready 1 after reset; a follow-up op 000 returns 0x0.
